// File: rtl/memory_access_unit.sv
// memory_access_unit: sequences ROM fetches, RAM loads and RAM stores through
// the external memory mux. It captures read data into IR/MDR and signals
// completion with a one-cycle done pulse.
module memory_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int ROM_LAT = 2,
  parameter int RAM_LAT = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [15:0]       store_data,
  input  logic [16:0]       EMUX_out,
  output logic              EMUX_select,
  output logic [ADDR_W-1:0] ROM_addr,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic [15:0]       RAM_data,
  output logic              RAM_wren,
  output logic [16:0]       IR_out,
  output logic [15:0]       MDR_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROM_WAIT,
    S_RAM_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  // The latencies are loaded into a 4-bit countdown, so 1..15 fits exactly.
  localparam logic [3:0] ROM_CNT = 4'(ROM_LAT);
  localparam logic [3:0] RAM_CNT = 4'(RAM_LAT);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_emux_select;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [15:0]         r_ram_data;
  logic                r_ram_wren;
  logic [16:0]         r_ir;
  logic [15:0]         r_mdr;
  logic                r_busy;
  logic                r_done;
  logic                w_cnt_last;

  // The countdown has reached the capture edge when it reads 1.
  assign w_cnt_last = (r_cnt == 4'd1);

  // Single state machine: it issues the access, counts the memory latency,
  // captures the read data and produces the done pulse.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_emux_select <= 1'b0;
      r_rom_addr    <= '0;
      r_ram_addr    <= '0;
      r_ram_data    <= 16'd0;
      r_ram_wren    <= 1'b0;
      r_ir          <= 17'd0;
      r_mdr         <= 16'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Fixed priority: fetch, then load, then store. Requests that lose
          // are not remembered; the requester keeps presenting them.
          if (fetch_req) begin
            r_rom_addr    <= pc;
            r_emux_select <= 1'b0;
            r_cnt         <= ROM_CNT;
            r_busy        <= 1'b1;
            r_state       <= S_ROM_WAIT;
          end else if (load_req) begin
            r_ram_addr    <= data_addr;
            r_emux_select <= 1'b1;
            r_cnt         <= RAM_CNT;
            r_busy        <= 1'b1;
            r_state       <= S_RAM_WAIT;
          end else if (store_req) begin
            r_ram_addr    <= data_addr;
            r_ram_data    <= store_data;
            r_ram_wren    <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_STORE;
          end
        end
        S_ROM_WAIT: begin
          if (w_cnt_last) begin
            r_ir    <= EMUX_out;
            r_cnt   <= 4'd0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RAM_WAIT: begin
          // Bit 16 of the mux output only matters for instructions.
          if (w_cnt_last) begin
            r_mdr   <= EMUX_out[15:0];
            r_cnt   <= 4'd0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_STORE: begin
          r_ram_wren <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          // Requests are still high here; they are ignored until IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign EMUX_select = r_emux_select;
  assign ROM_addr    = r_rom_addr;
  assign RAM_addr    = r_ram_addr;
  assign RAM_data    = r_ram_data;
  assign RAM_wren    = r_ram_wren;
  assign IR_out      = r_ir;
  assign MDR_out     = r_mdr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_memory_access_unit.sv
// Testbench for memory_access_unit. u_dut0 uses the default latency of 2, and
// a one-stage registered memory model drives its mux. u_dut1 uses latency 1,
// and a combinational memory model drives its mux.
module tb_memory_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Resetn;

  // ---------------- u_dut0 (latency 2) ----------------
  logic        f0, l0, s0;
  logic [15:0] pc0, da0, sd0;
  logic [16:0] emux0 = 17'd0;
  logic        sel0, wren0, busy0, done0;
  logic [15:0] rom_a0, ram_a0, ram_d0, mdr0;
  logic [16:0] ir0;

  // ---------------- u_dut1 (latency 1) ----------------
  logic        f1, l1, s1;
  logic [15:0] pc1, da1, sd1;
  logic [16:0] emux1;
  logic        sel1, wren1, busy1, done1;
  logic [15:0] rom_a1, ram_a1, ram_d1, mdr1;
  logic [16:0] ir1;

  memory_access_unit #(.ADDR_W(16), .ROM_LAT(2), .RAM_LAT(2)) u_dut0 (
    .Clock(clk), .Resetn(Resetn),
    .fetch_req(f0), .load_req(l0), .store_req(s0),
    .pc(pc0), .data_addr(da0), .store_data(sd0), .EMUX_out(emux0),
    .EMUX_select(sel0), .ROM_addr(rom_a0), .RAM_addr(ram_a0),
    .RAM_data(ram_d0), .RAM_wren(wren0), .IR_out(ir0), .MDR_out(mdr0),
    .busy(busy0), .done(done0)
  );

  memory_access_unit #(.ADDR_W(16), .ROM_LAT(1), .RAM_LAT(1)) u_dut1 (
    .Clock(clk), .Resetn(Resetn),
    .fetch_req(f1), .load_req(l1), .store_req(s1),
    .pc(pc1), .data_addr(da1), .store_data(sd1), .EMUX_out(emux1),
    .EMUX_select(sel1), .ROM_addr(rom_a1), .RAM_addr(ram_a1),
    .RAM_data(ram_d1), .RAM_wren(wren1), .IR_out(ir1), .MDR_out(mdr1),
    .busy(busy1), .done(done1)
  );

  // Memory contents: the fixed words come from the test plan, and a simple
  // formula covers every other address. RAM sets bit 16 to exercise discard.
  function automatic logic [16:0] rom_f(input logic [15:0] a);
    if (a == 16'h0005) return 17'h1ABCD;
    return {1'b0, a ^ 16'h5A5A};
  endfunction

  function automatic logic [16:0] ram_f(input logic [15:0] a);
    if (a == 16'h0010) return 17'h01234;
    return {1'b1, a + 16'h1111};
  endfunction

  // Registered memory: data is valid two edges after the address launch.
  always @(posedge clk) emux0 <= sel0 ? ram_f(ram_a0) : rom_f(rom_a0);
  // Combinational memory: data is valid one edge after the address launch.
  assign emux1 = sel1 ? ram_f(ram_a1) : rom_f(rom_a1);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        f, l, s;
    logic [15:0] pc, da, sd;
    int          tick;     // index of the edge after which done is seen (E0 = 0)
    logic        sel;      // EMUX_select after E0
    logic [16:0] ir;
    logic [15:0] mdr, rom_a, ram_a, ram_d;
    int          wren;     // cycles with RAM_wren high
  } vec_t;

  vec_t vec [9];

  initial begin
    int t_done;
    int wcnt;
    int dcnt;

    //            f     l     s     pc        da        sd        tk sel   ir         mdr       rom_a     ram_a     ram_d     wr
    vec[0] = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 2, 1'b0, 17'h1ABCD, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0};
    vec[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 2, 1'b1, 17'h1ABCD, 16'h1234, 16'h0005, 16'h0010, 16'h0000, 0};
    vec[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'hBEEF, 1, 1'b1, 17'h1ABCD, 16'h1234, 16'h0005, 16'h0020, 16'hBEEF, 1};
    vec[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0031, 16'h0000, 2, 1'b1, 17'h1ABCD, 16'h1142, 16'h0005, 16'h0031, 16'hBEEF, 0};
    vec[4] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 2, 1'b0, 17'h05B5A, 16'h1142, 16'h0100, 16'h0031, 16'hBEEF, 0};
    vec[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0040, 16'h1357, 1, 1'b0, 17'h05B5A, 16'h1142, 16'h0100, 16'h0040, 16'h1357, 1};
    vec[6] = '{1'b1, 1'b1, 1'b1, 16'h0007, 16'h0050, 16'hCAFE, 2, 1'b0, 17'h05A5D, 16'h1142, 16'h0007, 16'h0040, 16'h1357, 0};
    vec[7] = '{1'b0, 1'b1, 1'b1, 16'h0007, 16'h0050, 16'hCAFE, 2, 1'b1, 17'h05A5D, 16'h1161, 16'h0007, 16'h0050, 16'h1357, 0};
    vec[8] = '{1'b0, 1'b0, 1'b1, 16'h0007, 16'h0050, 16'hCAFE, 1, 1'b1, 17'h05A5D, 16'h1161, 16'h0007, 16'h0050, 16'hCAFE, 1};

    f0 = 0; l0 = 0; s0 = 0; pc0 = 0; da0 = 0; sd0 = 0;
    f1 = 0; l1 = 0; s1 = 0; pc1 = 0; da1 = 0; sd1 = 0;
    Resetn = 1'b0;
    #3;
    chk("rst_sel", {31'd0, sel0}, 0);
    chk("rst_rom_addr", {16'd0, rom_a0}, 0);
    chk("rst_ram_addr", {16'd0, ram_a0}, 0);
    chk("rst_ir", {15'd0, ir0}, 0);
    chk("rst_mdr", {16'd0, mdr0}, 0);
    chk("rst_busy_done_wren", {29'd0, busy0, done0, wren0}, 0);
    @(negedge clk);
    Resetn = 1'b1;
    tick();

    // ---------- latency-1 instance: capture at E1 ----------
    f1 = 1; pc1 = 16'h0005;
    tick();
    chk("l1_fetch_e0_done", {31'd0, done1}, 0);
    chk("l1_fetch_e0_ir", {15'd0, ir1}, 0);
    tick();
    chk("l1_fetch_e1_ir", {15'd0, ir1}, 32'h1ABCD);
    chk("l1_fetch_e1_done", {31'd0, done1}, 1);
    f1 = 0;
    tick();
    chk("l1_fetch_exit", {30'd0, busy1, done1}, 0);
    l1 = 1; da1 = 16'h0010;
    tick();
    chk("l1_load_e0_sel", {31'd0, sel1}, 1);
    tick();
    chk("l1_load_e1_mdr", {16'd0, mdr1}, 32'h1234);
    chk("l1_load_e1_done", {31'd0, done1}, 1);
    l1 = 0;
    tick();
    chk("l1_load_exit", {30'd0, busy1, done1}, 0);
    $display("txn l1: fetch ir=0x%0h load mdr=0x%0h", ir1, mdr1);

    // ---------- table-driven transactions on the latency-2 instance ----------
    for (int i = 0; i < 9; i++) begin
      f0 = vec[i].f; l0 = vec[i].l; s0 = vec[i].s;
      pc0 = vec[i].pc; da0 = vec[i].da; sd0 = vec[i].sd;
      t_done = -1;
      wcnt = 0;
      for (int k = 0; k < 20 && t_done < 0; k++) begin
        tick();
        if (k == 0) begin
          chk($sformatf("v%0d_sel_e0", i), {31'd0, sel0}, {31'd0, vec[i].sel});
          chk($sformatf("v%0d_busy_e0", i), {31'd0, busy0}, 1);
        end
        if (wren0) wcnt++;
        if (done0) t_done = k;
      end
      chk($sformatf("v%0d_done_edge", i), t_done, vec[i].tick);
      chk($sformatf("v%0d_ir", i), {15'd0, ir0}, {15'd0, vec[i].ir});
      chk($sformatf("v%0d_mdr", i), {16'd0, mdr0}, {16'd0, vec[i].mdr});
      chk($sformatf("v%0d_rom_addr", i), {16'd0, rom_a0}, {16'd0, vec[i].rom_a});
      chk($sformatf("v%0d_ram_addr", i), {16'd0, ram_a0}, {16'd0, vec[i].ram_a});
      chk($sformatf("v%0d_ram_data", i), {16'd0, ram_d0}, {16'd0, vec[i].ram_d});
      chk($sformatf("v%0d_wren_cycles", i), wcnt, vec[i].wren);
      f0 = 0; l0 = 0; s0 = 0;
      tick();
      chk($sformatf("v%0d_exit", i), {30'd0, busy0, done0}, 0);
      $display("txn v%0d: f=%0b l=%0b s=%0b done_edge=%0d ir=0x%0h mdr=0x%0h ram_addr=0x%0h ram_data=0x%0h",
               i, vec[i].f, vec[i].l, vec[i].s, t_done, ir0, mdr0, ram_a0, ram_d0);
    end

    // ---------- request held through DONE: next accept at E_L+2 ----------
    f0 = 1; pc0 = 16'h0005;
    tick();                        // E0
    pc0 = 16'h0009;
    tick();                        // E1
    chk("hold_e1_done", {31'd0, done0}, 0);
    tick();                        // E2
    chk("hold_e2_done", {31'd0, done0}, 1);
    chk("hold_e2_ir", {15'd0, ir0}, 32'h1ABCD);
    tick();                        // E3: leaves DONE, no re-accept
    chk("hold_e3_idle", {30'd0, busy0, done0}, 0);
    tick();                        // E4: re-accepted
    chk("hold_e4_busy", {31'd0, busy0}, 1);
    chk("hold_e4_rom_addr", {16'd0, rom_a0}, 32'h0009);
    f0 = 0;
    t_done = -1;
    for (int k = 1; k < 20 && t_done < 0; k++) begin
      tick();
      if (done0) t_done = k;
    end
    chk("hold_second_done_edge", t_done, 2);
    chk("hold_second_ir", {15'd0, ir0}, 32'h05A53);
    tick();
    $display("txn hold: second fetch ir=0x%0h", ir0);

    // ---------- asynchronous reset during RAM_WAIT ----------
    l0 = 1; da0 = 16'h0060;
    tick();                        // E0
    chk("rst_mid_sel_e0", {31'd0, sel0}, 1);
    tick();                        // E1, capture would follow at E2
    #2;
    Resetn = 1'b0;
    #1;
    chk("rst_mid_sel", {31'd0, sel0}, 0);
    chk("rst_mid_ram_addr", {16'd0, ram_a0}, 0);
    chk("rst_mid_ir_mdr", {ir0, mdr0[14:0]}, 0);
    chk("rst_mid_rom_ram_data", {rom_a0, ram_d0}, 0);
    chk("rst_mid_busy_done_wren", {29'd0, busy0, done0, wren0}, 0);
    #1;
    Resetn = 1'b1;
    l0 = 0;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done0) dcnt++;
    end
    chk("rst_mid_no_done", dcnt, 0);
    chk("rst_mid_idle", {31'd0, busy0}, 0);
    f0 = 1; pc0 = 16'h0005;
    t_done = -1;
    for (int k = 0; k < 20 && t_done < 0; k++) begin
      tick();
      if (done0) t_done = k;
    end
    f0 = 0;
    chk("post_rst_done_edge", t_done, 2);
    chk("post_rst_ir", {15'd0, ir0}, 32'h1ABCD);
    chk("post_rst_mdr", {16'd0, mdr0}, 0);
    tick();
    $display("txn reset: post-reset fetch ir=0x%0h", ir0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
